// File: rtl/pulse_event_dispatcher_pkg.sv
// Shared constants and helpers for the pulse event dispatcher.
package pulse_event_dispatcher_pkg;

  localparam int MAX_EVENT_COUNT = 64;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/pulse_event_dispatcher_if.sv
// Valid/ready dispatch channel carrying an event index.
interface pulse_event_dispatcher_if #(
  parameter int INDEX_WIDTH = 3
) ();
  logic                   event_valid;
  logic                   event_ready;
  logic [INDEX_WIDTH-1:0] event_index;

  modport master (output event_valid, output event_index, input event_ready);
  modport slave  (input event_valid, input event_index, output event_ready);
endinterface

// File: rtl/pulse_event_dispatcher_arbiter_round_robin.sv
// Round-robin arbiter: searches upward from last_granted+1 with wrap.
module arbiter_round_robin #(
  parameter int N  = 8,
  parameter int IW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_granted,
  output logic [N-1:0]  grant,
  output logic          any,
  output logic [IW-1:0] index
);
  import pulse_event_dispatcher_pkg::*;

  // Wide enough to hold last_granted + N without overflow for any legal N.
  localparam int SUM_W = clog2(MAX_EVENT_COUNT) + 2;

  logic [SUM_W-1:0] pos;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    index = '0;
    pos   = '0;
    for (int i = 1; i <= N; i++) begin
      pos = SUM_W'(last_granted) + SUM_W'(i);
      if (pos >= SUM_W'(N)) pos = pos - SUM_W'(N);
      if (!any && req[IW'(pos)]) begin
        grant[IW'(pos)] = 1'b1;
        any             = 1'b1;
        index           = IW'(pos);
      end
    end
  end
endmodule

// File: rtl/pulse_event_dispatcher.sv
// Latches per-source event pulses and dispatches them one at a time,
// round-robin, over a valid/ready channel; tracks sticky overflow.
module pulse_event_dispatcher #(
  parameter int EVENT_COUNT = 8,
  parameter int INDEX_WIDTH = 3
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic [EVENT_COUNT-1:0] pulses_in,
  input  logic [EVENT_COUNT-1:0] overflow_clear,
  output logic [EVENT_COUNT-1:0] pending_out,
  output logic [EVENT_COUNT-1:0] overflow_out,
  pulse_event_dispatcher_if.master evt
);
  import pulse_event_dispatcher_pkg::*;

  logic [EVENT_COUNT-1:0] pending, overflow, grant, dispatch_clr, ovf_set;
  logic                   any, load, valid_q;
  logic [INDEX_WIDTH-1:0] arb_index, index_q, last_granted;

  arbiter_round_robin #(.N(EVENT_COUNT), .IW(INDEX_WIDTH)) u_arb (
    .req          (pending),
    .last_granted (last_granted),
    .grant        (grant),
    .any          (any),
    .index        (arb_index)
  );

  assign load         = !valid_q || evt.event_ready;
  assign dispatch_clr = load ? grant : '0;
  // A pulse landing on a bit being dispatched this edge re-arms it rather
  // than overflowing; only a still-pending bit can overflow.
  assign ovf_set      = pulses_in & pending & ~dispatch_clr;

  always_ff @(posedge clock) begin
    if (clear) begin
      pending      <= '0;
      overflow     <= '0;
      valid_q      <= 1'b0;
      index_q      <= '0;
      last_granted <= INDEX_WIDTH'(EVENT_COUNT - 1);
    end else begin
      pending  <= (pending & ~dispatch_clr) | pulses_in;
      overflow <= (overflow & ~overflow_clear) | ovf_set;
      if (load) begin
        valid_q <= any;
        if (any) begin
          index_q      <= arb_index;
          last_granted <= arb_index;
        end
      end
    end
  end

  assign pending_out     = pending;
  assign overflow_out    = overflow;
  assign evt.event_valid = valid_q;
  assign evt.event_index = index_q;
endmodule
